// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - shared types and helpers for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'b00,
        HOLD    = 2'b01,
        RELEASE = 2'b10,
        RUN     = 2'b11
    } seq_state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        POR  = 2'b01,
        BTN  = 2'b10,
        SW   = 2'b11
    } rst_cause_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - reset sources in, domain resets and status out
interface rst_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    import rst_seq_pkg::*;

    logic                   RST_n_in;
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   all_ready;
    logic                   busy;
    rst_cause_t             cause;

    modport master (
        output RST_n_in,
        output sw_rst_req,
        input  dom_rst_n,
        input  all_ready,
        input  busy,
        input  cause
    );

    modport slave (
        input  RST_n_in,
        input  sw_rst_req,
        output dom_rst_n,
        output all_ready,
        output busy,
        output cause
    );

endinterface

// File: rtl/rst_sequencer_btn_debounce.sv
// rtl/rst_sequencer_btn_debounce.sv - push-button synchroniser and low-level debounce
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic RST_n_in,
    output logic btn_low,
    output logic btn_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   btn_low_q;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], RST_n_in};
        if (btn_s) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser resets to "released" so a power-on never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            cnt_q     <= '0;
            btn_low_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            btn_low_q <= btn_low;
        end
    end

    assign btn_low = (cnt_q == DEB_MAX);
    assign btn_evt = btn_low & ~btn_low_q;

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - reset sequencer: debounced button/sw reset, hold, staggered domain release
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8,
    parameter int NUM_DOMAINS     = 3,
    parameter int STAGGER_CYCLES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    rst_sequencer_if.slave  bus
);
    localparam int CNT_MAX = max_int(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int IW      = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

    seq_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    rst_cause_t             cause_q, cause_d;

    logic btn_low;
    logic btn_evt;
    logic rst_evt;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .rst      (rst),
        .RST_n_in (bus.RST_n_in),
        .btn_low  (btn_low),
        .btn_evt  (btn_evt)
    );

    assign rst_evt = btn_evt | bus.sw_rst_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    // A held button parks the FSM in ASSERT; everything else counts forward.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ASSERT: begin
                if (!btn_low) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (rst_evt) begin
                    state_d = ASSERT;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (NUM_DOMAINS == 1) ? RUN : RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (rst_evt) begin
                    state_d = ASSERT;
                end else if (cnt_q == STAG_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q + 1'b1 == IDX_LAST) begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (rst_evt) begin
                    state_d = ASSERT;
                end
            end
            default: state_d = ASSERT;
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge.
    always_comb begin
        dom_d = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            dom_d[i] = (state_d == RUN) || ((state_d == RELEASE) && (IW'(i) <= idx_d));
        end
        ready_d = (state_d == RUN);
        busy_d  = (state_d != RUN);
        cause_d = cause_q;
        if ((state_q != ASSERT) && rst_evt) begin
            cause_d = btn_evt ? BTN : SW;
        end
    end

    assign bus.dom_rst_n = dom_q;
    assign bus.all_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.cause     = cause_q;

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset controller that generalises the two-flop reset synchroniser into a full reset sequencer for the Knight's Tour robot top level. Brings an asynchronous push-button reset and a software reset request into the `clk` domain, filters button glitches, holds reset for a guaranteed minimum time, then releases `NUM_DOMAINS` active-low domain resets one at a time in fixed order. Sits directly under the top level, feeding `rst_n`-style resets to the UART/command, motion-control and sensor subsystems.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `RST_n_in`; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 16: consecutive synchronised-low cycles that qualify a button press; must be ≥ 1.
- `HOLD_CYCLES`, 8: minimum cycles all domains stay in reset after the reset source clears; must be ≥ 1.
- `NUM_DOMAINS`, 3: number of domain reset outputs; must be ≥ 1.
- `STAGGER_CYCLES`, 4: cycles between consecutive domain releases; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high block reset (power-on).
- `RST_n_in`  in  1  raw push-button, asynchronous, active-low.
- `sw_rst_req`  in  1  single-cycle software reset request, synchronous to `clk`.
- `dom_rst_n`  out  NUM_DOMAINS  per-domain active-low resets; bit 0 is released first.
- `all_ready`  out  1  high only when every domain is out of reset.
- `busy`  out  1  high while the sequencer is not in RUN.
- `cause`  out  2  last reset source: 00 none, 01 POR, 10 button, 11 software.

## Operation
- `rst` high at an edge: state ASSERT, `dom_rst_n` = 0, `all_ready` = 0, `busy` = 1, `cause` = 01, synchroniser flops = 1 (button released), debounce counter = 0, all counters = 0.
- Synchroniser: `RST_n_in` passes through `SYNC_STAGES` flops to give `btn_s`. Only `btn_s` is used downstream.
- Debounce: the counter increments on each edge with `btn_s` = 0 and saturates at `DEBOUNCE_CYCLES`. It clears on any edge with `btn_s` = 1. `btn_low` is high while the count equals `DEBOUNCE_CYCLES`. `btn_evt` is the rising edge of `btn_low`.
- FSM states: ASSERT, HOLD, RELEASE, RUN.
  - ASSERT: all `dom_rst_n` low. Moves to HOLD, clearing the counter, on the first edge where `btn_low` = 0. A held button keeps the FSM in ASSERT indefinitely.
  - HOLD: counts `HOLD_CYCLES` edges, then moves to RELEASE with domain index k = 0.
  - RELEASE: sets `dom_rst_n[k]` high, then waits `STAGGER_CYCLES` edges before releasing bit k+1. After bit `NUM_DOMAINS`-1 is released, moves to RUN.
  - RUN: `busy` = 0. `all_ready` = 1.
- Reset event: `btn_evt` or `sw_rst_req` in HOLD, RELEASE or RUN.
  - The next state is ASSERT.
  - All `dom_rst_n` go low, `all_ready` goes low and `busy` goes high on that same edge.
  - `cause` is updated on that edge.
  - Partial release sequences are abandoned and restart from bit 0.
- Simultaneous button event and `sw_rst_req`: the button wins and `cause` = 10.
- `sw_rst_req` while in ASSERT is ignored. `cause` is unchanged.
- `cause` holds its value until the next reset event or `rst`.
- `rst` asserted mid-sequence overrides everything and returns all state to the reset values above.

## Timing
- All outputs are registered, with no combinational paths from inputs to outputs.
- After `rst` falls, let E1 be the first edge sampling `rst` = 0 with the button released. ASSERT→HOLD occurs at E1.
- `dom_rst_n[k]` rises at edge E(1 + HOLD_CYCLES + k·STAGGER_CYCLES). With defaults, bits 0/1/2 rise at E9/E13/E17.
- `all_ready` rises on the same edge as the last domain release, and `busy` falls on that edge.
- Button: when `RST_n_in` falls, `dom_rst_n` goes to all-zero exactly `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 edges later (defaults: 19).
- Button glitch: a low pulse shorter than `DEBOUNCE_CYCLES` cycles after synchronisation has no effect on any output.
- `sw_rst_req` sampled high in HOLD, RELEASE or RUN: `dom_rst_n` is all-zero on the next edge (1-cycle latency).
- Button release: after a button reset, `btn_s` returning to 1 gives ASSERT→HOLD on the following edge. The release sequence then follows the `rst` timing above.

## Structure
- Package `rst_seq_pkg`:
  - `seq_state_t` enum (ASSERT, HOLD, RELEASE, RUN).
  - `rst_cause_t` enum (NONE, POR, BTN, SW).
  - `cause` is driven as `rst_cause_t`.
- Sub-module `btn_debounce`: the synchroniser chain plus the debounce counter. It is parametrised by `SYNC_STAGES` and `DEBOUNCE_CYCLES` and outputs `btn_low` and `btn_evt`.
- Counter widths use `$clog2` of the largest count plus 1.

## Test plan
- POR, defaults: pulse `rst` for 3 cycles with the button released → `dom_rst_n` = 000, then 001 at E9, 011 at E13, 111 at E17; `all_ready` = 1 at E17; `cause` = 01.
- Glitch: in RUN, drive `RST_n_in` low for 10 cycles → outputs unchanged, `all_ready` stays 1.
- Button: in RUN, hold `RST_n_in` low for 40 cycles → `dom_rst_n` = 000 at edge 19 after the fall, held while low; release sequence restarts after the release; `cause` = 10.
- Software reset mid-release: pulse `sw_rst_req` when `dom_rst_n` = 011 → 000 on the next edge, sequence restarts from bit 0, `cause` = 11.
- Simultaneous: `sw_rst_req` on the same edge as `btn_evt` → single ASSERT entry, `cause` = 10.
- Parameter sweep with `NUM_DOMAINS` = 1, `STAGGER_CYCLES` = 1, `HOLD_CYCLES` = 1, `SYNC_STAGES` = 3 → `dom_rst_n[0]` and `all_ready` rise at E2.
